// File: rtl/traffic_phase_scheduler_pkg.sv
// rtl/traffic_phase_scheduler_pkg.sv - shared light/phase types and phase helpers
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        HW_GREEN,
        HW_YELLOW,
        ALL_RED_1,
        CR_GREEN,
        CR_YELLOW,
        ALL_RED_2
    } phase_t;

    function automatic light_t hw_head(input phase_t p);
        case (p)
            HW_GREEN:  return GREEN;
            HW_YELLOW: return YELLOW;
            default:   return RED;
        endcase
    endfunction

    function automatic light_t cr_head(input phase_t p);
        case (p)
            CR_GREEN:  return GREEN;
            CR_YELLOW: return YELLOW;
            default:   return RED;
        endcase
    endfunction

    // The schedule is a fixed ring; every phase has exactly one successor.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            HW_GREEN:  return HW_YELLOW;
            HW_YELLOW: return ALL_RED_1;
            ALL_RED_1: return CR_GREEN;
            CR_GREEN:  return CR_YELLOW;
            CR_YELLOW: return ALL_RED_2;
            default:   return HW_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - tick/sensor inputs and light-head outputs of the scheduler
interface traffic_phase_scheduler_if #(
    parameter int CNT_W = 6
);
    import traffic_pkg::*;

    logic             clk_en;
    logic             car;
    light_t           hw_light;
    light_t           cr_light;
    phase_t           phase;
    logic [CNT_W-1:0] remain;
    logic             phase_done;

    modport master (
        output clk_en, car,
        input  hw_light, cr_light, phase, remain, phase_done
    );

    modport slave (
        input  clk_en, car,
        output hw_light, cr_light, phase, remain, phase_done
    );

endinterface

// File: rtl/traffic_phase_scheduler_timer.sv
// rtl/traffic_phase_scheduler_timer.sv - loadable down-counter that saturates at zero
module phase_timer #(
    parameter int               CNT_W     = 6,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] cnt;

    // A load wins over a tick, so a phase entry always starts from a full count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero  = (cnt == '0);
    assign value = cnt;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - phase sequencer for the highway / country-road intersection
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int HW_GREEN_MIN = 25,
    parameter int YELLOW_DUR   = 4,
    parameter int ALL_RED_DUR  = 1,
    parameter int CR_GREEN_MAX = 15,
    parameter int CNT_W        = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_phase_scheduler_if.slave bus
);

    function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
        case (p)
            HW_GREEN:             return CNT_W'(HW_GREEN_MIN - 1);
            HW_YELLOW, CR_YELLOW: return CNT_W'(YELLOW_DUR - 1);
            CR_GREEN:             return CNT_W'(CR_GREEN_MAX - 1);
            default:              return CNT_W'(ALL_RED_DUR - 1);
        endcase
    endfunction

    logic             car_m;
    logic             car_s;
    phase_t           state;
    phase_t           nxt;
    light_t           hw_q;
    light_t           cr_q;
    logic             done_q;
    logic             advance;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_m <= 1'b0;
            car_s <= 1'b0;
        end else begin
            car_m <= bus.car;
            car_s <= car_m;
        end
    end

    // HW_GREEN parks at zero until a car is seen; CR_GREEN may release early.
    always_comb begin
        advance = 1'b0;
        nxt     = next_phase(state);
        case (state)
            HW_GREEN: advance = bus.clk_en && cnt_zero && car_s;
            CR_GREEN: advance = bus.clk_en && (!car_s || cnt_zero);
            default:  advance = bus.clk_en && cnt_zero;
        endcase
    end

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (CNT_W'(HW_GREEN_MIN - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (advance),
        .load_val (dur_m1(nxt)),
        .tick     (bus.clk_en),
        .zero     (cnt_zero),
        .value    (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HW_GREEN;
            hw_q   <= GREEN;
            cr_q   <= RED;
            done_q <= 1'b0;
        end else begin
            done_q <= advance;
            if (advance) begin
                state <= nxt;
                hw_q  <= hw_head(nxt);
                cr_q  <= cr_head(nxt);
            end
        end
    end

    assign bus.hw_light   = hw_q;
    assign bus.cr_light   = cr_q;
    assign bus.phase      = state;
    assign bus.remain     = cnt;
    assign bus.phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench with a tick-level reference model
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int HG = 4;
    localparam int YD = 2;
    localparam int AR = 1;
    localparam int CG = 3;

    typedef struct {
        phase_t ph;
        light_t hw;
        light_t cr;
        int     rem;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t   sbq[$];
    phase_t log_ph[$];
    int     log_tk[$];
    exp_t   mon_e;
    phase_t last_phase = HW_GREEN;
    int     cr_enter   = 0;
    int     tick_count = 0;

    phase_t m_phase = HW_GREEN;
    int     m_ticks = 0;
    bit     car_p1  = 0;
    bit     car_p2  = 0;

    traffic_phase_scheduler_if #(.CNT_W(6)) bus ();

    traffic_phase_scheduler #(
        .HW_GREEN_MIN (HG),
        .YELLOW_DUR   (YD),
        .ALL_RED_DUR  (AR),
        .CR_GREEN_MAX (CG),
        .CNT_W        (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int dur(input phase_t p);
        if (p == HW_GREEN) return HG;
        if (p == CR_GREEN) return CG;
        if (p == HW_YELLOW || p == CR_YELLOW) return YD;
        return AR;
    endfunction

    function automatic light_t exp_hw(input phase_t p);
        if (p == HW_GREEN) return GREEN;
        if (p == HW_YELLOW) return YELLOW;
        return RED;
    endfunction

    function automatic light_t exp_cr(input phase_t p);
        if (p == CR_GREEN) return GREEN;
        if (p == CR_YELLOW) return YELLOW;
        return RED;
    endfunction

    function automatic phase_t ring_after(input phase_t p);
        return phase_t'((int'(p) + 1) % 6);
    endfunction

    // One clk_en tick of the reference: phase lasts until its rule fires, counted in ticks since entry.
    task automatic model_tick(input bit cs);
        bit expired;
        bit go;
        expired = (m_ticks >= dur(m_phase) - 1);
        if (m_phase == HW_GREEN)      go = expired && cs;
        else if (m_phase == CR_GREEN) go = expired || !cs;
        else                          go = expired;
        if (go) begin
            m_phase = ring_after(m_phase);
            m_ticks = 0;
            sbq.push_back('{m_phase, exp_hw(m_phase), exp_cr(m_phase), dur(m_phase) - 1});
        end else begin
            m_ticks++;
        end
    endtask

    // The FSM sees the sensor two clocks late through the synchronizer.
    task automatic step(input bit en, input bit c);
        bit cs;
        bus.clk_en = en;
        bus.car    = c;
        cs     = car_p2;
        car_p2 = car_p1;
        car_p1 = c;
        @(posedge clk);
        #1;
        if (en) begin
            tick_count++;
            model_tick(cs);
        end
    endtask

    task automatic tick(input bit c);
        repeat (3) step(1'b0, c);
        step(1'b1, c);
    endtask

    task automatic reset_model();
        sbq.delete();
        log_ph.delete();
        log_tk.delete();
        m_phase    = HW_GREEN;
        m_ticks    = 0;
        car_p1     = 0;
        car_p2     = 0;
        tick_count = 0;
        last_phase = HW_GREEN;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_phase"}, int'(bus.phase), int'(HW_GREEN));
        chk({tag, "_hw"}, int'(bus.hw_light), int'(GREEN));
        chk({tag, "_cr"}, int'(bus.cr_light), int'(RED));
        chk({tag, "_remain"}, int'(bus.remain), HG - 1);
        chk({tag, "_done"}, int'(bus.phase_done), 0);
    endtask

    task automatic do_reset();
        bus.clk_en = 1'b0;
        bus.car    = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic drained(input string tag);
        step(1'b0, bus.car);
        chk({tag, "_sb_drained"}, sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.hw_light != RED && bus.cr_light != RED) begin
                errors++;
                $display("FAIL safety hw=%0d cr=%0d required one RED", bus.hw_light, bus.cr_light);
            end
            if (bus.phase_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase_done actual=1 required=0 phase=%0d", bus.phase);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_phase", int'(bus.phase), int'(mon_e.ph));
                    chk("sb_hw", int'(bus.hw_light), int'(mon_e.hw));
                    chk("sb_cr", int'(bus.cr_light), int'(mon_e.cr));
                    chk("sb_remain", int'(bus.remain), mon_e.rem);
                end
                chk("ring_order", int'(bus.phase), int'(ring_after(last_phase)));
                if (bus.phase == CR_GREEN) cr_enter = tick_count;
                if (bus.phase == CR_YELLOW) begin
                    checks++;
                    if (tick_count - cr_enter < 1 || tick_count - cr_enter > CG) begin
                        errors++;
                        $display("FAIL cr_green_len actual=%0d required=1..%0d", tick_count - cr_enter, CG);
                    end
                end
                log_ph.push_back(bus.phase);
                log_tk.push_back(tick_count);
                last_phase = bus.phase;
            end
        end
    end

    initial begin
        phase_t t2_ph[6];
        int     t2_tk[6];
        int     found;
        bit     c;
        t2_ph = '{HW_YELLOW, ALL_RED_1, CR_GREEN, CR_YELLOW, ALL_RED_2, HW_GREEN};
        t2_tk = '{4, 6, 7, 10, 12, 13};
        rst = 1'b1;
        bus.clk_en = 1'b0;
        bus.car = 1'b0;

        // Idle highway: remain counts down then parks at zero.
        do_reset();
        check_reset_vals("reset");
        for (int k = 1; k <= 40; k++) begin
            tick(1'b0);
            if (k <= 5 || k == 40) begin
                chk("t1_remain", int'(bus.remain), (k < HG) ? HG - 1 - k : 0);
                chk("t1_phase", int'(bus.phase), int'(HW_GREEN));
            end
        end
        chk("t1_no_transitions", log_ph.size(), 0);

        // Car present from the start: full cycle with fixed tick positions.
        do_reset();
        for (int k = 1; k <= 13; k++) tick(1'b1);
        drained("t2");
        chk("t2_count", log_ph.size(), 6);
        for (int i = 0; i < 6 && i < log_ph.size(); i++) begin
            chk("t2_phase", int'(log_ph[i]), int'(t2_ph[i]));
            chk("t2_tick", log_tk[i], t2_tk[i]);
        end

        // Car leaves one tick after CR_GREEN entry, drop placed at each clk of the period.
        for (int j = 0; j < 4; j++) begin
            do_reset();
            for (int k = 1; k <= 7; k++) tick(1'b1);
            chk("t3_in_cr_green", int'(bus.phase), int'(CR_GREEN));
            for (int s = 0; s < 4; s++) step(s == 3, s < j);
            repeat (2) tick(1'b0);
            found = -1;
            for (int i = 0; i < log_ph.size(); i++)
                if (log_ph[i] == CR_YELLOW && found < 0) found = log_tk[i];
            chk("t3_yellow_tick", found, (j <= 1) ? 8 : 9);
            drained("t3");
        end

        // Single-clk pulses that fall between ticks never reach a tick edge.
        do_reset();
        for (int k = 1; k <= 6; k++) tick(1'b0);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 2 : 3);
            for (int s = 0; s < 4; s++) step(s == 3, s == p);
        end
        repeat (2) tick(1'b0);
        chk("t4_pulse_ignored", log_ph.size(), 0);
        chk("t4_phase", int'(bus.phase), int'(HW_GREEN));
        drained("t4");

        // Asynchronous reset in the middle of CR_GREEN.
        do_reset();
        for (int k = 1; k <= 8; k++) tick(1'b1);
        step(1'b0, 1'b1);
        chk("t5_pre_phase", int'(bus.phase), int'(CR_GREEN));
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.car = 1'b0;
        reset_model();
        check_reset_vals("t5_after");

        // Random sensor with the timebase every 4th clk.
        do_reset();
        c = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0) c = ~c;
            step((k % 4) == 3, c);
        end
        drained("t6a");

        // clk_en tied high, random sensor.
        do_reset();
        c = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) c = ~c;
            step(1'b1, c);
        end
        drained("t6b");
        chk("t6b_saw_transitions", (log_ph.size() > 100) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Central sequencer for the highway / country-road intersection. Owns the single shared phase timer and the phase state machine.
- Decides when the highway yields to the country road, based on the country-road car sensor, and drives both light heads.
- Sits between the timebase tick generator (clk_en) and the light drivers. Replaces ad-hoc start/timeout handshakes between per-road FSMs with one arbitrated schedule.

Parameters:
- HW_GREEN_MIN, 25, minimum highway green in clk_en ticks (>=1)
- YELLOW_DUR, 4, yellow duration in ticks, both roads (>=1)
- ALL_RED_DUR, 1, all-red clearance in ticks after each yellow (>=1)
- CR_GREEN_MAX, 15, maximum country-road green in ticks (>=1)
- CNT_W, 6, phase counter width; must hold max(parameter)-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  one-cycle timebase tick; all timing counts these
- car  in  1  country-road vehicle sensor, asynchronous to clk
- hw_light  out  2  highway head, light_t encoding
- cr_light  out  2  country-road head, light_t encoding
- phase  out  3  current phase_t, for debug/display
- remain  out  CNT_W  ticks left in current timed phase (counter value)
- phase_done  out  1  one-clk pulse on every phase transition

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. rst clears all flops immediately, independent of clk.
- car passes through a 2-flop synchronizer (reset 0) to give car_s. The state machine uses only car_s.
- Phases (phase_t): HW_GREEN, HW_YELLOW, ALL_RED_1, CR_GREEN, CR_YELLOW, ALL_RED_2.
- Lights by phase:
  - HW_GREEN: hw=GREEN, cr=RED
  - HW_YELLOW: hw=YELLOW, cr=RED
  - ALL_RED_1 and ALL_RED_2: both RED
  - CR_GREEN: hw=RED, cr=GREEN
  - CR_YELLOW: hw=RED, cr=YELLOW
- Counter rule:
  - On entry to phase P, cnt loads DUR(P)-1.
  - DUR is HW_GREEN_MIN, YELLOW_DUR, ALL_RED_DUR or CR_GREEN_MAX as applicable.
  - On a clk_en cycle with cnt==0, the transition rule is evaluated. Otherwise, on a clk_en cycle, cnt decrements.
  - Cycles without clk_en change nothing. A plain timed phase therefore lasts exactly DUR clk_en ticks.
- Transitions (evaluated only on clk_en):
  - HW_GREEN: when cnt==0, hold at 0. Go to HW_YELLOW on the first tick with cnt==0 and car_s==1. car_s during the minimum green is ignored; if car_s is still high at expiry, leave on the expiry tick.
  - HW_YELLOW -> ALL_RED_1 -> CR_GREEN: purely timed.
  - CR_GREEN -> CR_YELLOW: on any tick with car_s==0 (early release) or cnt==0 (max reached). Otherwise cnt decrements.
  - CR_YELLOW -> ALL_RED_2 -> HW_GREEN: purely timed.
- state, cnt, hw_light, cr_light and phase are registered and all update on the same edge. Lights are glitch-free.
- phase_done is high for exactly the one clk cycle following a transition edge.
- Reset values:
  - state=HW_GREEN, cnt=HW_GREEN_MIN-1
  - hw_light=GREEN, cr_light=RED, phase=HW_GREEN, remain=HW_GREEN_MIN-1
  - phase_done=0, sync flops=0
- Reset mid-phase: returns to HW_GREEN with a full minimum green. No yellow is inserted.
- Safety invariant: hw_light and cr_light are never both non-RED. Each green is always preceded by the opposite yellow plus all-red. Bench asserts both.
- clk_en held high every cycle is legal; the FSM then runs at clk rate.

Decomposition:
- Package traffic_pkg:
  - light_t enum logic[1:0]: RED=2'b00, YELLOW=2'b01, GREEN=2'b10
  - phase_t enum logic[2:0] in the listed order, starting at 0
- Sub-module phase_timer: loadable down-counter with load, load_val, tick, zero flag and value output.
- Synchronizer is two inline flops; no sub-module.

Test Plan:
Params: HW_GREEN_MIN=4, YELLOW_DUR=2, ALL_RED_DUR=1, CR_GREEN_MAX=3; clk_en every 4th clk.
1. Reset, car=0 for 40 ticks -> stays HW_GREEN; remain counts 3,2,1,0 then holds 0; no phase_done after reset.
2. car=1 from tick 1 -> HW_YELLOW entered on tick 4 (car ignored before expiry); then ALL_RED_1 at tick 6, CR_GREEN at tick 7, CR_YELLOW at tick 10 (max), ALL_RED_2 at tick 12, HW_GREEN at tick 13; phase_done pulses 6 times.
3. car drops one tick after CR_GREEN entry -> CR_YELLOW on the first tick where car_s==0; CR green lasts 1-2 ticks, never more than 3.
4. car pulse of 1 clk between ticks -> no transition (sampled only on clk_en); car held high across HW_GREEN expiry -> leave on the exact expiry tick.
5. rst asserted during CR_GREEN, asynchronous mid-cycle -> immediately hw=GREEN, cr=RED, remain=3, phase_done=0.
6. clk_en tied high with random car for 10k clk -> safety invariant never violated; every phase sequence follows the fixed ring.
